// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler for four ultrasonic range sensors: trigger pulse,
// echo-width measurement in centimetres, timeout handling and inter-channel quiet gap.
`timescale 1ns/1ps
module ultrasonic_scheduler #(
  parameter int TRIG_CYCLES    = 500,
  parameter int CM_CYCLES      = 2900,  // must be >= 2
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int GAP_CYCLES     = 3000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  enable_mask,
  input  logic [3:0]  echo,
  output logic [3:0]  trigger,
  output logic [15:0] dist_cm,
  output logic [1:0]  dist_ch,
  output logic        dist_valid,
  output logic        timeout,
  output logic        busy
);

  localparam int TMAX = (TIMEOUT_CYCLES > GAP_CYCLES)
                      ? ((TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES)
                      : ((GAP_CYCLES > TRIG_CYCLES) ? GAP_CYCLES : TRIG_CYCLES);
  localparam int TW = $clog2(TMAX + 1);
  localparam int CW = $clog2(CM_CYCLES + 1);

  localparam logic [TW-1:0] TRIG_LOAD = TW'(TRIG_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CM_LOAD   = CW'(CM_CYCLES);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    echo_s1_q, echo_s2_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] sub_q, sub_d;
  logic [15:0]   cm_q, cm_d;
  logic [1:0]    ch_q, ch_d;
  logic [3:0]    trigger_q, trigger_d;
  logic [15:0]   dist_cm_q, dist_cm_d;
  logic [1:0]    dist_ch_q, dist_ch_d;
  logic          dist_valid_q, dist_valid_d;
  logic          timeout_q, timeout_d;
  logic          busy_q, busy_d;

  logic [1:0] next_ch, cand;
  logic       found;
  logic       echo_sel;

  // Search starts one past the last served channel; i==4 wraps to that channel itself.
  always_comb begin
    next_ch = ch_q;
    cand    = ch_q;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = ch_q + 2'(i);
      if (!found && enable_mask[cand]) begin
        next_ch = cand;
        found   = 1'b1;
      end
    end
  end

  assign echo_sel = echo_s2_q[ch_q];

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    sub_d        = sub_q;
    cm_d         = cm_q;
    ch_d         = ch_q;
    trigger_d    = trigger_q;
    dist_cm_d    = dist_cm_q;
    dist_ch_d    = dist_ch_q;
    dist_valid_d = 1'b0;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          ch_d      = next_ch;
          trigger_d = 4'b0001 << next_ch;
          timer_d   = TRIG_LOAD;
          state_d   = TRIG;
        end
      end
      TRIG: begin
        if (timer_q == '0) begin
          trigger_d = '0;
          timer_d   = TO_LOAD;
          state_d   = WAIT_RISE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      WAIT_RISE: begin
        // The rise cycle itself is the first counted echo-high cycle.
        if (echo_sel) begin
          cm_d    = '0;
          sub_d   = CM_LOAD - 1'b1;
          timer_d = TO_LOAD;
          state_d = MEASURE;
        end else if (timer_q == '0) begin
          dist_valid_d = 1'b1;
          dist_cm_d    = 16'hFFFF;
          dist_ch_d    = ch_q;
          timeout_d    = 1'b1;
          timer_d      = GAP_LOAD;
          state_d      = GAP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      MEASURE: begin
        if (!echo_sel) begin
          dist_valid_d = 1'b1;
          dist_cm_d    = cm_q;
          dist_ch_d    = ch_q;
          timeout_d    = 1'b0;
          timer_d      = GAP_LOAD;
          state_d      = GAP;
        end else if (timer_q == '0) begin
          dist_valid_d = 1'b1;
          dist_cm_d    = 16'hFFFF;
          dist_ch_d    = ch_q;
          timeout_d    = 1'b1;
          timer_d      = GAP_LOAD;
          state_d      = GAP;
        end else begin
          timer_d = timer_q - 1'b1;
          if (sub_q == CW'(1)) begin
            sub_d = CM_LOAD;
            if (cm_q != 16'hFFFE) cm_d = cm_q + 16'd1;
          end else begin
            sub_d = sub_q - 1'b1;
          end
        end
      end
      GAP: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // ch_q resets to 3 so that channel 0 is the first candidate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      echo_s1_q    <= '0;
      echo_s2_q    <= '0;
      timer_q      <= '0;
      sub_q        <= '0;
      cm_q         <= '0;
      ch_q         <= 2'd3;
      trigger_q    <= '0;
      dist_cm_q    <= '0;
      dist_ch_q    <= '0;
      dist_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      echo_s1_q    <= echo;
      echo_s2_q    <= echo_s1_q;
      timer_q      <= timer_d;
      sub_q        <= sub_d;
      cm_q         <= cm_d;
      ch_q         <= ch_d;
      trigger_q    <= trigger_d;
      dist_cm_q    <= dist_cm_d;
      dist_ch_q    <= dist_ch_d;
      dist_valid_q <= dist_valid_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
    end
  end

  assign trigger    = trigger_q;
  assign dist_cm    = dist_cm_q;
  assign dist_ch    = dist_ch_q;
  assign dist_valid = dist_valid_q;
  assign timeout    = timeout_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler with small timing parameters;
// a vector table drives normal measurements, hand sequences cover timeouts and reset.
`timescale 1ns/1ps
module tb_ultrasonic_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  enable_mask;
  logic [3:0]  echo;
  logic [3:0]  trigger;
  logic [15:0] dist_cm;
  logic [1:0]  dist_ch;
  logic        dist_valid;
  logic        timeout;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_fall   = 0;
  int t_rise   = 0;
  int t_rep    = 0;

  typedef struct {
    logic [3:0]  mask;
    int          ch;
    int          len;
    logic [15:0] cm;
    logic        to;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  ultrasonic_scheduler #(
    .TRIG_CYCLES(5), .CM_CYCLES(10), .TIMEOUT_CYCLES(200), .GAP_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .enable_mask(enable_mask), .echo(echo),
    .trigger(trigger), .dist_cm(dist_cm), .dist_ch(dist_ch),
    .dist_valid(dist_valid), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) chk("trig_onehot0", 32'($onehot0(trigger)), 32'd1);
  end

  task automatic wait_trig(input int ch);
    int k = 0;
    int width = 0;
    while (trigger == 4'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    t_rise = cyc;
    chk("trig_seen", 32'(trigger != 4'b0), 32'd1);
    chk("trig_ch", 32'(trigger), 32'(4'b0001 << ch));
    chk("busy_in_trig", 32'(busy), 32'd1);
    k = 0;
    while (trigger != 4'b0 && k < 50) begin
      width++;
      @(negedge clk);
      k++;
    end
    chk("trig_width", 32'(width), 32'd5);
    t_fall = cyc;
  endtask

  task automatic wait_report(input int ch, input logic [15:0] cm, input logic to, input int lat);
    int k = 0;
    while (!dist_valid && k < 600) begin
      @(negedge clk);
      k++;
    end
    t_rep = cyc;
    chk("valid_seen", 32'(dist_valid), 32'd1);
    chk("dist_ch", 32'(dist_ch), 32'(ch));
    chk("dist_cm", 32'(dist_cm), 32'(cm));
    chk("timeout", 32'(timeout), 32'(to));
    if (lat != 0) chk("report_latency", 32'(t_rep - t_fall), 32'(lat));
    @(negedge clk);
    chk("valid_one_cycle", 32'(dist_valid), 32'd0);
    chk("hold_cm", 32'(dist_cm), 32'(cm));
    chk("busy_in_gap", 32'(busy), 32'd1);
  endtask

  task automatic drive_echo(input int ch, input int len);
    if (len > 0) begin
      echo[ch] = 1'b1;
      repeat (len) @(negedge clk);
      echo[ch] = 1'b0;
    end
  endtask

  initial begin
    int k;
    logic [15:0] prev_cm;
    vecs[0] = '{4'b0001, 0, 57, 16'd5,    1'b0, 0};
    vecs[1] = '{4'b1010, 1, 30, 16'd3,    1'b0, 0};
    vecs[2] = '{4'b1010, 3, 30, 16'd3,    1'b0, 0};
    vecs[3] = '{4'b1010, 1, 30, 16'd3,    1'b0, 0};
    vecs[4] = '{4'b1010, 3, 30, 16'd3,    1'b0, 0};
    vecs[5] = '{4'b0100, 2, 0,  16'hFFFF, 1'b1, 200};

    reset = 1'b1;
    enable_mask = 4'b0000;
    echo = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_trigger", 32'(trigger), 32'd0);
    chk("rst_dist_cm", 32'(dist_cm), 32'd0);
    chk("rst_dist_ch", 32'(dist_ch), 32'd0);
    chk("rst_valid", 32'(dist_valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Empty mask: scheduler must stay idle.
    repeat (40) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_trigger", 32'(trigger), 32'd0);
    end
    enable_mask = 4'b1000;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!trigger[3] && k < 3);
    chk("mask_to_trig3_le2", 32'(k <= 2 && trigger[3]), 32'd1);
    wait_trig(3);
    drive_echo(3, 25);
    wait_report(3, 16'd2, 1'b0, 0);
    prev_cm = 16'd2;

    for (int i = 0; i < 6; i++) begin
      enable_mask = vecs[i].mask;
      wait_trig(vecs[i].ch);
      chk("hold_between", 32'(dist_cm), 32'(prev_cm));
      drive_echo(vecs[i].ch, vecs[i].len);
      wait_report(vecs[i].ch, vecs[i].cm, vecs[i].to, vecs[i].lat);
      prev_cm = vecs[i].cm;
    end

    // Echo stuck high: 3 sync/rise cycles plus 200 MEASURE cycles.
    enable_mask = 4'b0001;
    wait_trig(0);
    echo[0] = 1'b1;
    wait_report(0, 16'hFFFF, 1'b1, 203);
    enable_mask = 4'b1111;
    k = t_rep;
    wait_trig(1);
    chk("gap_restart", 32'(t_rise - k), 32'd21);
    // echo[0] still high must not count for channel 1.
    wait_report(1, 16'hFFFF, 1'b1, 200);
    echo[0] = 1'b0;

    // Reset during MEASURE on channel 2.
    wait_trig(2);
    echo[2] = 1'b1;
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("reset_trigger", 32'(trigger), 32'd0);
    chk("reset_valid", 32'(dist_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    echo = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    k = 0;
    while (trigger == 4'b0 && k < 10) begin
      chk("no_valid_after_reset", 32'(dist_valid), 32'd0);
      @(negedge clk);
      k++;
    end
    chk("after_reset_ch0", 32'(trigger), 32'd1);
    chk("after_reset_cm", 32'(dist_cm), 32'd0);

    // Reset while a trigger pulse is active must clear it without a clock edge.
    @(negedge clk);
    chk("trig_still_high", 32'(trigger), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("reset_trig_async", 32'(trigger), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ultrasonic_scheduler.md
ULTRASONIC_SCHEDULER -- requirements
Module: ultrasonic_scheduler

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, 500, trigger pulse width in clk cycles (10 us at 50 MHz).
REQ-002 SHALL have parameter CM_CYCLES, 2900, echo-high clk cycles per centimetre.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 1500000, maximum wait for echo rise and maximum echo-high duration.
REQ-004 SHALL have parameter GAP_CYCLES, 3000000, quiet time between consecutive channel measurements.
REQ-005 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port enable_mask  input  4  per-channel enable; a 0 bit means the channel is skipped.
REQ-008 SHALL have port echo  input  4  asynchronous echo lines from sensors 0..3.
REQ-009 SHALL have port trigger  output  4  trigger lines to sensors 0..3.
REQ-010 SHALL have port dist_cm  output  16  last completed distance in cm.
REQ-011 SHALL have port dist_ch  output  2  channel that dist_cm belongs to.
REQ-012 SHALL have port dist_valid  output  1  one-cycle pulse when dist_cm/dist_ch/timeout update.
REQ-013 SHALL have port timeout  output  1  result of the current dist_valid was a timeout.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL pass each echo bit through a 2-flop synchronizer; all echo-related latencies below count from the synchronized signal.
REQ-016 SHALL implement FSM states IDLE, TRIG, WAIT_RISE, MEASURE, GAP.
REQ-017 IDLE: if enable_mask != 0, SHALL select the next enabled channel in round-robin order after the last served channel (channel 0 first after reset) and go to TRIG; otherwise stay in IDLE.
REQ-018 TRIG: SHALL drive trigger[ch]=1 for exactly TRIG_CYCLES cycles, with all other trigger bits 0, then go to WAIT_RISE.
REQ-019 WAIT_RISE: on synchronized echo[ch]=1, SHALL go to MEASURE; after TIMEOUT_CYCLES without a rise, SHALL report a timeout and go to GAP.
REQ-020 MEASURE: SHALL count echo-high cycles and increment the cm count each CM_CYCLES cycles; the cm count saturates at 16'hFFFE.
REQ-021 MEASURE: on synchronized echo[ch] falling, SHALL report the cm count (partial CM_CYCLES fractions are truncated) with timeout=0, then go to GAP.
REQ-022 MEASURE: if echo stays high for TIMEOUT_CYCLES, SHALL report a timeout and go to GAP.
REQ-023 A report SHALL set dist_ch=ch and pulse dist_valid for one cycle. On timeout it SHALL also set dist_cm=16'hFFFF and timeout=1.
REQ-024 dist_cm, dist_ch and timeout SHALL hold their value between reports.
REQ-025 GAP: SHALL wait GAP_CYCLES cycles with all triggers 0, then go to IDLE.
REQ-026 enable_mask SHALL be sampled only in IDLE; clearing a bit mid-measurement SHALL NOT abort that measurement.
REQ-027 Echo activity on channels other than the selected channel SHALL be ignored.
REQ-028 An echo already high on entry to WAIT_RISE SHALL count as a rise.

Reset
REQ-029 While reset=1, SHALL force state=IDLE, trigger=0, dist_cm=0, dist_ch=0, dist_valid=0, timeout=0, busy=0, all counters 0, round-robin pointer so channel 0 is next.
REQ-030 Reset asserted mid-operation SHALL drop trigger within the same cycle (asynchronously) and discard the partial measurement with no dist_valid.

Verification
REQ-031 Use TRIG_CYCLES=5, CM_CYCLES=10, TIMEOUT_CYCLES=200, GAP_CYCLES=20. Mask=4'b0001; echo[0] high for 57 cycles after the trigger -> trigger[0] high for 5 cycles; dist_valid with dist_cm=5, dist_ch=0, timeout=0.
REQ-032 Mask=4'b1010; echoes of 30 cycles each -> channel order 1,3,1,3; dist_cm=3 on each report; no other trigger bit is ever set.
REQ-033 Mask=4'b0100; no echo -> dist_valid 200 cycles after WAIT_RISE entry with dist_cm=16'hFFFF, timeout=1, dist_ch=2.
REQ-034 Mask=4'b0001; echo stuck high -> timeout report after 200 MEASURE cycles; the next cycle starts after 20 GAP cycles.
REQ-035 Assert reset during MEASURE -> trigger=0 and dist_valid=0 immediately; after release, the first trigger goes to channel 0.
REQ-036 Mask=4'b0000 -> busy=0 and trigger=0 indefinitely; setting mask=4'b1000 -> trigger[3] rises within 2 cycles.
